control_fsm: RTL and testbench
==============================

// Module: control_fsm
// PURPOSE
//  Multi-cycle control unit for the accumulator CPU; successor to the single-cycle combinational decoder.
//  Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and registers all datapath controls.
//  Handshakes with instruction and data memory, which may stall. A watchdog flags hung memory.
//  Sits between the instruction register/fetch path and the ALU, register file and memory ports.
// PARAMETERS
//  OPCODE_W     5   opcode width; decode uses opcode[OPCODE_W-1:OPCODE_W-4], must be >= 5
//  ALU_MODE_W   3   alu_mode width; values are the project ALU_MODE_* encodings
//  TIMEOUT      16  max cycles waiting on any ack before fault; must be >= 2
// PORTS
//  clk           in   1           clock, all state updates on rising edge
//  rst_n         in   1           synchronous reset, active-low
//  opcode        in   OPCODE_W    opcode from instruction register, valid from DECODE onward
//  imem_ack      in   1           instruction fetch complete
//  dmem_ack      in   1           data access (lb/sb) complete
//  branch_cond   in   1           ALU compare result for blt/bge/beq/bneq, valid in EXEC
//  imem_req      out  1           instruction fetch request
//  ir_load       out  1           load instruction register
//  alu_mode      out  ALU_MODE_W  ALU operation
//  alu_a_sel     out  1           0 = accumulator, 1 = PC
//  alu_b_sel     out  1           0 = register, 1 = immediate
//  dmem_req      out  1           data memory request
//  mem_write_en  out  1           data memory write, qualified by dmem_req
//  rf_write_en   out  1           register file write strobe
//  rf_write_sel  out  1           0 = ALU result, 1 = load data
//  pc_inc        out  1           PC <= PC + 1
//  pc_load       out  1           PC <= ALU result (jump/taken branch)
//  fault         out  1           sticky watchdog fault
// BEHAVIOUR
//  Reset: state = FETCH; all outputs 0; watchdog counter 0; fault cleared. Reset mid-instruction aborts it
//   with no rf/mem write or PC update in the reset cycle.
//  States (one-hot or binary, implementer's choice): FETCH, DECODE, EXEC, MEM, WB, HALT.
//  FETCH: imem_req=1 held until imem_ack. On ack: ir_load=1 for that cycle -> DECODE.
//  DECODE: one cycle. Latch the decoded controls from opcode -> EXEC.
//  Class decode on op = opcode[top 4 bits]:
//   000x add/addi, 001x sh/shi, 0100 not, 0101 and, 0110 or, 0111 xor -> ALU op, rf write.
//   1000 cpy/cpypc, 1001 lb, 1010 sb, 1011 jmpadr -> BYPASS_A. 11xx jmpi/branches -> ADD.
//   alu_b_sel = 11xx, or 00x1 (addi, shi). alu_a_sel = 11xx, or the full cpypc opcode (op 1000, bit0=1).
//  EXEC: alu_mode/alu_a_sel/alu_b_sel driven. Next: lb/sb -> MEM. jmpadr/jmpi -> pc_load=1 -> FETCH.
//   Branches: branch_cond=1 -> pc_load=1, else pc_inc=1 -> FETCH. All other ops -> WB.
//  MEM: dmem_req=1 held; mem_write_en=1 for sb. On dmem_ack: sb -> pc_inc=1 -> FETCH; lb -> WB.
//  WB: rf_write_en=1 for exactly one cycle. rf_write_sel=1 only for lb. pc_inc=1 -> FETCH.
//  Reserved op encodings: treated as a NOP (no writes), pc_inc=1 in EXEC -> FETCH.
//  Strobe rules: rf_write_en, pc_inc, pc_load, ir_load are single-cycle pulses; they are never asserted
//   together except pc_inc with rf_write_en in WB.
//  Watchdog: counts consecutive cycles in FETCH or MEM without the matching ack. It clears on ack or on
//   state exit. On reaching TIMEOUT: fault=1, all reqs drop to 0 -> HALT. HALT is left only by reset.
//  Ack arriving the same cycle the count reaches TIMEOUT: the ack wins; no fault.
//  Acks arriving outside the matching state are ignored.
//  Latency: ALU op 4 cycles (with 1-cycle ack); lb 5; sb 4; jump/branch 3.
// TESTING
//  addi (op 0001) with imem_ack 1-cycle -> ir_load@1, alu_b_sel=1, rf_write_en once, pc_inc in WB, 4 cycles.
//  lb (op 1001), dmem_ack after 3 cycles -> dmem_req high 3 cycles, mem_write_en=0, then WB with rf_write_sel=1.
//  sb (op 1010) -> mem_write_en=1 with dmem_req, rf_write_en never asserted, pc_inc once.
//  beq, branch_cond=1 then 0 -> pc_load=1 / pc_inc=1 respectively in EXEC; alu_a_sel=1, alu_b_sel=1.
//  TIMEOUT=4, dmem_ack never -> fault=1 after 4 MEM cycles, dmem_req=0, stays HALT until rst_n=0.
//  rst_n=0 during MEM of sb -> next cycle all outputs 0, state FETCH, no write issued; ack at count=TIMEOUT -> no fault.

Source files
------------

// File: rtl/control_fsm_if.sv
// Handshake/control bundle between control_fsm and the CPU datapath.
// master is the control unit; slave is the datapath/memory side.
interface control_fsm_if #(
    parameter int OPCODE_W   = 5,
    parameter int ALU_MODE_W = 3
);
    logic [OPCODE_W-1:0]   opcode_i;
    logic                  imem_ack_i;
    logic                  dmem_ack_i;
    logic                  branch_cond_i;
    logic                  imem_req_o;
    logic                  ir_load_o;
    logic [ALU_MODE_W-1:0] alu_mode_o;
    logic                  alu_a_sel_o;
    logic                  alu_b_sel_o;
    logic                  dmem_req_o;
    logic                  mem_write_en_o;
    logic                  rf_write_en_o;
    logic                  rf_write_sel_o;
    logic                  pc_inc_o;
    logic                  pc_load_o;
    logic                  fault_o;

    modport master (
        input  opcode_i, imem_ack_i, dmem_ack_i, branch_cond_i,
        output imem_req_o, ir_load_o, alu_mode_o, alu_a_sel_o,
        output alu_b_sel_o, dmem_req_o, mem_write_en_o,
        output rf_write_en_o, rf_write_sel_o, pc_inc_o,
        output pc_load_o, fault_o
    );

    modport slave (
        output opcode_i, imem_ack_i, dmem_ack_i, branch_cond_i,
        input  imem_req_o, ir_load_o, alu_mode_o, alu_a_sel_o,
        input  alu_b_sel_o, dmem_req_o, mem_write_en_o,
        input  rf_write_en_o, rf_write_sel_o, pc_inc_o,
        input  pc_load_o, fault_o
    );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle control unit for the accumulator CPU: FETCH/DECODE/EXEC/MEM/WB
// sequencing with registered datapath controls and a memory-ack watchdog.
module control_fsm #(
    parameter int OPCODE_W   = 5,
    parameter int ALU_MODE_W = 3,
    parameter int TIMEOUT    = 16
) (
    input logic           clk,
    input logic           rst_n,
    control_fsm_if.master bus
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [ALU_MODE_W-1:0] ALU_ADD = ALU_MODE_W'(0);
    localparam logic [ALU_MODE_W-1:0] ALU_SH  = ALU_MODE_W'(1);
    localparam logic [ALU_MODE_W-1:0] ALU_NOT = ALU_MODE_W'(2);
    localparam logic [ALU_MODE_W-1:0] ALU_AND = ALU_MODE_W'(3);
    localparam logic [ALU_MODE_W-1:0] ALU_OR  = ALU_MODE_W'(4);
    localparam logic [ALU_MODE_W-1:0] ALU_XOR = ALU_MODE_W'(5);
    localparam logic [ALU_MODE_W-1:0] ALU_BYP = ALU_MODE_W'(6);

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_e;

    typedef enum logic [2:0] {
        K_ALU, K_LB, K_SB, K_JMP, K_BR, K_NOP
    } kind_e;

    state_e                state_q;
    kind_e                 kind_q;
    kind_e                 kind_d;
    logic [ALU_MODE_W-1:0] mode_q, mode_d;
    logic                  a_q, a_d;
    logic                  b_q, b_d;
    logic [CNT_W-1:0]      cnt_q;
    logic                  imem_req_q, dmem_req_q, we_q;
    logic                  rf_we_q, rf_sel_q;
    logic                  pc_inc_q, pc_load_q, br_q, fault_q;

    logic [3:0] op;
    logic       lsb;

    assign op  = bus.opcode_i[OPCODE_W-1 -: 4];
    assign lsb = bus.opcode_i[0];

    // bit0 has no meaning for lb/sb/jmpadr, so those variants are reserved
    always_comb begin
        mode_d = ALU_ADD;
        kind_d = K_ALU;
        unique casez (op)
            4'b000?: mode_d = ALU_ADD;
            4'b001?: mode_d = ALU_SH;
            4'b0100: mode_d = ALU_NOT;
            4'b0101: mode_d = ALU_AND;
            4'b0110: mode_d = ALU_OR;
            4'b0111: mode_d = ALU_XOR;
            4'b1000: mode_d = ALU_BYP;
            4'b1001: begin
                mode_d = ALU_BYP;
                kind_d = lsb ? K_NOP : K_LB;
            end
            4'b1010: begin
                mode_d = ALU_BYP;
                kind_d = lsb ? K_NOP : K_SB;
            end
            4'b1011: begin
                mode_d = ALU_BYP;
                kind_d = lsb ? K_NOP : K_JMP;
            end
            4'b1100: kind_d = K_JMP;
            4'b1101, 4'b111?: kind_d = K_BR;
        endcase
        a_d = (op[3:2] == 2'b11) | ((op == 4'b1000) & lsb);
        b_d = (op[3:2] == 2'b11) | ((op[3:2] == 2'b00) & op[0]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            kind_q     <= K_ALU;
            {mode_q, a_q, b_q} <= '0;
            cnt_q      <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            we_q       <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_sel_q   <= 1'b0;
            pc_inc_q   <= 1'b0;
            pc_load_q  <= 1'b0;
            br_q       <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            rf_we_q   <= 1'b0;
            rf_sel_q  <= 1'b0;
            pc_inc_q  <= 1'b0;
            pc_load_q <= 1'b0;
            br_q      <= 1'b0;
            unique case (state_q)
                FETCH: begin
                    if (imem_req_q && bus.imem_ack_i) begin
                        imem_req_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= DECODE;
                    end else if (imem_req_q && cnt_q == CNT_LAST) begin
                        imem_req_q <= 1'b0;
                        cnt_q      <= '0;
                        fault_q    <= 1'b1;
                        state_q    <= HALT;
                    end else begin
                        // first cycle after reset only raises the request
                        imem_req_q <= 1'b1;
                        if (imem_req_q) cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DECODE: begin
                    kind_q    <= kind_d;
                    mode_q    <= mode_d;
                    a_q       <= a_d;
                    b_q       <= b_d;
                    pc_load_q <= (kind_d == K_JMP);
                    pc_inc_q  <= (kind_d == K_NOP);
                    br_q      <= (kind_d == K_BR);
                    state_q   <= EXEC;
                end
                EXEC: begin
                    if (kind_q == K_LB || kind_q == K_SB) begin
                        dmem_req_q <= 1'b1;
                        we_q       <= (kind_q == K_SB);
                        state_q    <= MEM;
                    end else if (kind_q == K_ALU) begin
                        rf_we_q  <= 1'b1;
                        pc_inc_q <= 1'b1;
                        state_q  <= WB;
                    end else begin
                        {mode_q, a_q, b_q} <= '0;
                        imem_req_q <= 1'b1;
                        state_q    <= FETCH;
                    end
                end
                MEM: begin
                    if (bus.dmem_ack_i) begin
                        dmem_req_q <= 1'b0;
                        we_q       <= 1'b0;
                        cnt_q      <= '0;
                        if (kind_q == K_SB) begin
                            {mode_q, a_q, b_q} <= '0;
                            imem_req_q <= 1'b1;
                            state_q    <= FETCH;
                        end else begin
                            rf_we_q  <= 1'b1;
                            rf_sel_q <= 1'b1;
                            pc_inc_q <= 1'b1;
                            state_q  <= WB;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        {mode_q, a_q, b_q} <= '0;
                        dmem_req_q <= 1'b0;
                        we_q       <= 1'b0;
                        cnt_q      <= '0;
                        fault_q    <= 1'b1;
                        state_q    <= HALT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WB: begin
                    {mode_q, a_q, b_q} <= '0;
                    imem_req_q <= 1'b1;
                    state_q    <= FETCH;
                end
                HALT: state_q <= HALT;
                default: state_q <= HALT;
            endcase
        end
    end

    // ack/compare-qualified strobes resolve in the cycle the input arrives
    assign bus.imem_req_o     = imem_req_q;
    assign bus.ir_load_o      = rst_n & imem_req_q & bus.imem_ack_i;
    assign bus.alu_mode_o     = mode_q;
    assign bus.alu_a_sel_o    = a_q;
    assign bus.alu_b_sel_o    = b_q;
    assign bus.dmem_req_o     = rst_n & dmem_req_q;
    assign bus.mem_write_en_o = rst_n & we_q;
    assign bus.rf_write_en_o  = rst_n & rf_we_q;
    assign bus.rf_write_sel_o = rf_sel_q;
    assign bus.pc_inc_o       = rst_n & (pc_inc_q
                              | (br_q & ~bus.branch_cond_i)
                              | (dmem_req_q & we_q & bus.dmem_ack_i));
    assign bus.pc_load_o      = rst_n & (pc_load_q
                              | (br_q & bus.branch_cond_i));
    assign bus.fault_o        = fault_q;
endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: per-cycle output vectors against an
// instruction-level reference model, directed cases then random ones.
module tb_control_fsm;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    control_fsm_if #(.OPCODE_W(5), .ALU_MODE_W(3)) bus ();

    control_fsm #(
        .OPCODE_W(5), .ALU_MODE_W(3), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    function automatic logic [13:0] mk(
        logic ireq, logic irl, logic [2:0] m, logic a, logic b,
        logic dreq, logic we, logic rfwe, logic rfsel,
        logic inc, logic ld, logic flt);
        return {ireq, irl, m, a, b, dreq, we, rfwe, rfsel, inc, ld, flt};
    endfunction

    function automatic logic [13:0] observed();
        return {bus.imem_req_o, bus.ir_load_o, bus.alu_mode_o,
                bus.alu_a_sel_o, bus.alu_b_sel_o, bus.dmem_req_o,
                bus.mem_write_en_o, bus.rf_write_en_o,
                bus.rf_write_sel_o, bus.pc_inc_o, bus.pc_load_o,
                bus.fault_o};
    endfunction

    // ALU mode by opcode class: add=0 sh=1 not=2 and=3 or=4 xor=5 bypass=6
    function automatic logic [2:0] mode_of(int v);
        if (v < 2) return 3'd0;
        if (v < 4) return 3'd1;
        if (v < 8) return 3'(v - 2);
        if (v < 12) return 3'd6;
        return 3'd0;
    endfunction

    // 0 alu/cpy, 1 lb, 2 sb, 3 jump, 4 branch, 5 reserved
    function automatic int kind_of(int v, logic lsb);
        if (v <= 8) return 0;
        if (v >= 9 && v <= 11 && lsb) return 5;
        if (v == 9) return 1;
        if (v == 10) return 2;
        if (v == 11 || v == 12) return 3;
        return 4;
    endfunction

    task automatic step(input logic [13:0] exp, input string tag);
        logic [13:0] obs;
        #1;
        obs = observed();
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
        @(negedge clk);
    endtask

    task automatic noise();
        bus.dmem_ack_i    = 1'($urandom);
        bus.branch_cond_i = 1'($urandom);
        bus.imem_ack_i    = 1'($urandom);
    endtask

    task automatic reset_check(input logic [13:0] during);
        noise();
        rst_n = 1'b0;
        step(during, "reset_cycle");
        rst_n = 1'b1;
        bus.imem_ack_i = 1'b1;
        bus.dmem_ack_i = 1'b1;
        step('0, "after_reset");
    endtask

    task automatic halt_and_reset();
        logic [13:0] h;
        h = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            noise();
            step(h, "halt");
        end
        reset_check(h);
    endtask

    task automatic run_instr(input logic [4:0] opc, input int ideal,
                             input int ddel, input logic bc,
                             input int abort_mem);
        int v, kind;
        logic [2:0] m;
        logic a, b, lsb, sb, inc, ld;
        v = int'(opc[4:1]);
        lsb = opc[0];
        m = mode_of(v);
        kind = kind_of(v, lsb);
        a = (v >= 12) || (v == 8 && lsb);
        b = (v >= 12) || (v < 4 && v % 2 == 1);
        sb = (kind == 2);
        for (int k = 0; k < TO; k++) begin
            noise();
            bus.opcode_i = 5'($urandom);
            bus.imem_ack_i = (k == ideal);
            step(mk(1, k == ideal, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                 "fetch");
            if (k == ideal) break;
        end
        if (ideal >= TO) begin
            halt_and_reset();
            return;
        end
        noise();
        bus.opcode_i = opc;
        step('0, "decode");
        noise();
        bus.branch_cond_i = bc;
        inc = (kind == 5) || (kind == 4 && !bc);
        ld = (kind == 3) || (kind == 4 && bc);
        step(mk(0, 0, m, a, b, 0, 0, 0, 0, inc, ld, 0), "exec");
        if (kind == 0) begin
            noise();
            step(mk(0, 0, m, a, b, 0, 0, 1, 0, 1, 0, 0), "wb");
            return;
        end
        if (kind != 1 && kind != 2) return;
        for (int k = 0; k < TO; k++) begin
            noise();
            if (k == abort_mem) begin
                rst_n = 1'b0;
                bus.dmem_ack_i = 1'b1;
                step(mk(0, 0, m, a, b, 0, 0, 0, 0, 0, 0, 0), "mem_rst");
                rst_n = 1'b1;
                bus.imem_ack_i = 1'b1;
                step('0, "after_abort");
                return;
            end
            bus.dmem_ack_i = (k == ddel);
            step(mk(0, 0, m, a, b, 1, sb, 0, 0, sb && k == ddel, 0, 0),
                 "mem");
            if (k == ddel) break;
        end
        if (ddel >= TO) begin
            halt_and_reset();
            return;
        end
        if (kind == 1) begin
            noise();
            step(mk(0, 0, m, a, b, 0, 0, 1, 1, 1, 0, 0), "lb_wb");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.opcode_i = '0;
        bus.imem_ack_i = 1'b0;
        bus.dmem_ack_i = 1'b0;
        bus.branch_cond_i = 1'b0;
        @(negedge clk);
        step('0, "reset_state");
        rst_n = 1'b1;
        bus.imem_ack_i = 1'b1;
        step('0, "idle_fetch");

        run_instr(5'b00010, 0, 0, 1'b0, -1);
        run_instr(5'b10010, 1, 2, 1'b0, -1);
        run_instr(5'b10100, 0, 0, 1'b0, -1);
        run_instr(5'b11110, 0, 0, 1'b1, -1);
        run_instr(5'b11110, 2, 0, 1'b0, -1);
        run_instr(5'b11000, 0, 0, 1'b0, -1);
        run_instr(5'b10110, 0, 0, 1'b1, -1);
        run_instr(5'b10001, 0, 0, 1'b0, -1);
        run_instr(5'b00110, 0, 0, 1'b0, -1);
        run_instr(5'b01110, 0, 0, 1'b0, -1);
        run_instr(5'b10011, 0, 0, 1'b0, -1);
        run_instr(5'b10010, TO - 1, TO - 1, 1'b0, -1);
        run_instr(5'b10100, 0, TO - 1, 1'b0, -1);
        run_instr(5'b10010, 0, TO, 1'b0, -1);
        run_instr(5'b00000, TO, 0, 1'b0, -1);
        run_instr(5'b10100, 0, 3, 1'b0, 1);
        run_instr(5'b00011, 0, 0, 1'b0, -1);

        for (int n = 0; n < 60; n++) begin
            run_instr(5'($urandom),
                      ($urandom_range(0, 7) == 0) ? TO
                                                  : $urandom_range(0, TO - 1),
                      ($urandom_range(0, 7) == 0) ? TO
                                                  : $urandom_range(0, TO - 1),
                      1'($urandom),
                      ($urandom_range(0, 9) == 0) ? 0 : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
